// File: rtl/user_io_irq_pkg.sv
// Shared constants and helpers for the user I/O interrupt bank.
//   GRP_*       : register group selected by wbs_adr_i[7:4]
//   num_words() : 32-bit words needed to cover n pins
//   rw_merge()  : byte-lane merge for read/write registers
//   w1c_merge() : byte-lane write-one-to-clear merge
package user_io_irq_pkg;

  localparam logic [3:0] GRP_OUT       = 4'd0;
  localparam logic [3:0] GRP_OEB       = 4'd1;
  localparam logic [3:0] GRP_IN        = 4'd2;
  localparam logic [3:0] GRP_RISE_EN   = 4'd3;
  localparam logic [3:0] GRP_FALL_EN   = 4'd4;
  localparam logic [3:0] GRP_STATUS    = 4'd5;
  localparam logic [3:0] GRP_IRQ0_MASK = 4'd6;
  localparam logic [3:0] GRP_IRQ1_MASK = 4'd7;
  localparam logic [3:0] GRP_IRQ2_MASK = 4'd8;

  localparam int NUM_IRQ = 3;

  function automatic int num_words(input int n);
    return (n + 31) / 32;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{sel[b]}};
    return m;
  endfunction

  function automatic logic [31:0] rw_merge(input logic [31:0] old, input logic [31:0] dat,
                                           input logic [3:0] sel);
    logic [31:0] m;
    m = byte_mask(sel);
    return (old & ~m) | (dat & m);
  endfunction

  // Only bits written as 1 within enabled byte lanes are cleared.
  function automatic logic [31:0] w1c_merge(input logic [31:0] old, input logic [31:0] dat,
                                            input logic [3:0] sel);
    return old & ~(dat & byte_mask(sel));
  endfunction

endpackage

// File: rtl/user_io_edge_sync.sv
// Pad input synchroniser with edge detection.
//   clk, rst : clock, synchronous active-high reset
//   async_in : asynchronous pad inputs
//   sync     : synchronised value (s)
//   rise     : s & ~p, p being s delayed one cycle
//   fall     : ~s & p
module user_io_edge_sync
  import user_io_irq_pkg::*;
#(
  parameter int WIDTH  = 38,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // chain[0] is the first (metastable-exposed) stage.
  logic [STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]             prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/user_io_irq_bank.sv
// Wishbone GPIO bank with per-pin edge interrupts.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wbs_*              : Wishbone slave (single-cycle registered ack)
//   io_in              : asynchronous pad inputs
//   io_out, io_oeb     : pad outputs / active-low output enables
//   user_irq           : |(STATUS & IRQk_MASK), registered
module user_io_irq_bank
  import user_io_irq_pkg::*;
#(
  parameter int          NUM_IO      = 38,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic [2:0]        user_irq
);

  localparam int NW = num_words(NUM_IO);
  localparam int PW = NW * 32;
  // Registers are held word-padded; bits at or above NUM_IO are forced to 0.
  localparam logic [PW-1:0] PIN_MASK = {PW{1'b1}} >> (PW - NUM_IO);

  logic       hit, req, wr_en;
  logic [3:0] grp;
  logic [1:0] word;
  logic       unused_adr;

  assign hit        = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // ~ack keeps a held strobe from issuing back-to-back transfers.
  assign req        = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
  assign wr_en      = req & wbs_we_i;
  assign grp        = wbs_adr_i[7:4];
  assign word       = wbs_adr_i[3:2];
  assign unused_adr = ^wbs_adr_i[1:0];

  logic [PW-1:0]              out_r, oeb_r, rise_en, fall_en, status, status_nx;
  logic [NUM_IRQ-1:0][PW-1:0] irq_mask;
  logic [PW-1:0]              in_pw, set_pw;
  logic [NUM_IO-1:0]          sync_v, rise_v, fall_v;
  logic [31:0]                rdata;

  user_io_edge_sync #(.WIDTH(NUM_IO), .STAGES(SYNC_STAGES)) u_sync (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .async_in (io_in),
    .sync     (sync_v),
    .rise     (rise_v),
    .fall     (fall_v)
  );

  // Registered enables are used, so an enable written this cycle only
  // affects edges detected from the next cycle on.
  always_comb begin
    in_pw              = '0;
    in_pw[NUM_IO-1:0]  = sync_v;
    set_pw             = '0;
    set_pw[NUM_IO-1:0] = (rise_v & rise_en[NUM_IO-1:0]) | (fall_v & fall_en[NUM_IO-1:0]);
  end

  // Edge sets are OR'd in after the clear so a coincident set wins.
  always_comb begin
    status_nx = status;
    for (int w = 0; w < NW; w++)
      if (wr_en && grp == GRP_STATUS && word == 2'(w))
        status_nx[w*32 +: 32] = w1c_merge(status[w*32 +: 32], wbs_dat_i, wbs_sel_i);
    status_nx = (status_nx | set_pw) & PIN_MASK;
  end

  always_comb begin
    rdata = '0;
    for (int w = 0; w < NW; w++)
      if (word == 2'(w)) begin
        case (grp)
          GRP_OUT:       rdata = out_r[w*32 +: 32];
          GRP_OEB:       rdata = oeb_r[w*32 +: 32];
          GRP_IN:        rdata = in_pw[w*32 +: 32];
          GRP_RISE_EN:   rdata = rise_en[w*32 +: 32];
          GRP_FALL_EN:   rdata = fall_en[w*32 +: 32];
          GRP_STATUS:    rdata = status[w*32 +: 32];
          GRP_IRQ0_MASK: rdata = irq_mask[0][w*32 +: 32];
          GRP_IRQ1_MASK: rdata = irq_mask[1][w*32 +: 32];
          GRP_IRQ2_MASK: rdata = irq_mask[2][w*32 +: 32];
          default:       rdata = '0;
        endcase
        rdata = rdata & PIN_MASK[w*32 +: 32];
      end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      out_r     <= '0;
      oeb_r     <= PIN_MASK;
      rise_en   <= '0;
      fall_en   <= '0;
      status    <= '0;
      irq_mask  <= '0;
      user_irq  <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'h0;
      status    <= status_nx;
      for (int k = 0; k < NUM_IRQ; k++) user_irq[k] <= |(status & irq_mask[k]);
      for (int w = 0; w < NW; w++)
        if (wr_en && word == 2'(w)) begin
          case (grp)
            GRP_OUT:       out_r[w*32 +: 32] <=
                             rw_merge(out_r[w*32 +: 32], wbs_dat_i, wbs_sel_i) & PIN_MASK[w*32 +: 32];
            GRP_OEB:       oeb_r[w*32 +: 32] <=
                             rw_merge(oeb_r[w*32 +: 32], wbs_dat_i, wbs_sel_i) & PIN_MASK[w*32 +: 32];
            GRP_RISE_EN:   rise_en[w*32 +: 32] <=
                             rw_merge(rise_en[w*32 +: 32], wbs_dat_i, wbs_sel_i) & PIN_MASK[w*32 +: 32];
            GRP_FALL_EN:   fall_en[w*32 +: 32] <=
                             rw_merge(fall_en[w*32 +: 32], wbs_dat_i, wbs_sel_i) & PIN_MASK[w*32 +: 32];
            GRP_IRQ0_MASK: irq_mask[0][w*32 +: 32] <=
                             rw_merge(irq_mask[0][w*32 +: 32], wbs_dat_i, wbs_sel_i) & PIN_MASK[w*32 +: 32];
            GRP_IRQ1_MASK: irq_mask[1][w*32 +: 32] <=
                             rw_merge(irq_mask[1][w*32 +: 32], wbs_dat_i, wbs_sel_i) & PIN_MASK[w*32 +: 32];
            GRP_IRQ2_MASK: irq_mask[2][w*32 +: 32] <=
                             rw_merge(irq_mask[2][w*32 +: 32], wbs_dat_i, wbs_sel_i) & PIN_MASK[w*32 +: 32];
            default: ;
          endcase
        end
    end
  end

  assign io_out = out_r[NUM_IO-1:0];
  assign io_oeb = oeb_r[NUM_IO-1:0];

endmodule
